key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//   Consumes the slow tick from clk_divider (divided_clk) and debounces NUM_KEYS raw push-buttons.
//   Per key: 2-flop synchronizer, then a 4-state debounce FSM sampled only on divided_clk rising edges.
//   Each confirmed press yields one key code in a 1-entry output buffer with valid/ready handshake to the lock FSM.
//   Sits between the board buttons / clk_divider and the DigiLock code-entry logic; all logic on clk_in.
// PARAMETERS
//   NUM_KEYS      4   number of buttons; must be <= 2**CODE_W
//   CODE_W        2   width of key_code
//   STABLE_TICKS  2   consecutive equal tick samples needed to confirm press/release; legal range 2..15
// PORTS
//   clk_in       input   1          system clock (same clock that drives clk_divider)
//   rst          input   1          synchronous, active-high reset
//   divided_clk  input   1          slow clock from clk_divider, a level synchronous to clk_in; only its rising edge is used
//   btn_in       input   NUM_KEYS   raw asynchronous buttons, 1 = pressed
//   key_ready    input   1          consumer accepts key_code when key_valid & key_ready
//   drop_clr     input   1          clears key_drop
//   key_valid    output  1          output buffer holds an unconsumed key
//   key_code     output  CODE_W     index of pressed key; stable while key_valid=1
//   key_held     output  NUM_KEYS   1 while key FSM is in HELD or RELEASE_CHK
//   key_drop     output  1          sticky: a confirmed press was lost
// BEHAVIOUR
//   Reset (rst=1 at posedge clk_in): sync flops=0, div_d=1, all FSMs RELEASED, cnt=0, key_valid=0, key_code=0, key_held=0, key_drop=0.
//   Tick: tick = divided_clk & ~div_d; div_d <= divided_clk every cycle. div_d resets to 1, so divided_clk
//     high at reset release gives no tick. FSMs change state only in tick cycles.
//   Synchronizer: btn_s[i] = btn_in[i] after two clk_in flops; FSM samples btn_s.
//   FSM per key (cnt 4 bits), evaluated on tick:
//     RELEASED:    btn_s=1 -> PRESS_CHK, cnt=1; else stay.
//     PRESS_CHK:   btn_s=0 -> RELEASED; btn_s=1 & cnt==STABLE_TICKS-1 -> HELD + press event; else cnt++.
//     HELD:        btn_s=0 -> RELEASE_CHK, cnt=1; else stay.
//     RELEASE_CHK: btn_s=1 -> HELD (no new event); btn_s=0 & cnt==STABLE_TICKS-1 -> RELEASED; else cnt++.
//   One press event per press; holding never repeats. Event is internal, one cycle, in the tick cycle.
//   Latency: key_valid rises the clk_in cycle after the confirming tick cycle.
//   Arbitration: multiple events in one tick -> lowest index loaded; every other event dropped, key_drop<=1.
//   Buffer: load when event and (key_valid=0 or key_ready=1); key_valid & key_ready & no event -> key_valid<=0.
//     Event while key_valid=1 & key_ready=0 -> event dropped, buffer unchanged, key_drop<=1.
//   key_drop: set by any drop, cleared by drop_clr; set wins over simultaneous drop_clr.
//   key_held is registered FSM decode; it tracks the FSM with no added delay.
//   Reset mid-operation: everything returns to reset values; a button held through reset is re-debounced
//     and produces a fresh event after STABLE_TICKS ticks.
// TESTING  (STABLE_TICKS=2, divided_clk toggles every 8 clk_in cycles)
//   Reset release with divided_clk=1 -> no tick; key_valid=0, key_drop=0 until btn press.
//   btn_in=4'b0100 held clean 5 ticks -> exactly one key_valid pulse, key_code=2; key_held[2]=1 from confirming tick.
//   btn_in[1] bounces 1/0 on alternate ticks for 6 ticks -> no key_valid; key_held[1] stays 0.
//   btn_in=4'b1010 rise together -> key_code=1 delivered, key_drop=1; drop_clr pulse -> key_drop=0.
//   key_ready=0, press key0, release, press key3 -> key_code stays 0, key_drop=1; key_ready=1 -> key_valid=0 next cycle.
//   Hold key0 in HELD, assert rst 1 cycle, keep holding -> key_valid=0, key_held=0, then key_code=0 after 2 ticks.

Source files
------------

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS raw buttons against the divided_clk tick and delivers one key
// code per confirmed press through a single-entry valid/ready buffer.

module key_fsm #(
    parameter int STABLE_TICKS = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic tick,
    input  logic btn_s,
    output logic press_evt,
    output logic held
);
    typedef enum logic [1:0] {RELEASED, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       held_q, held_d;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= 4'd0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                RELEASED: if (btn_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = 4'd1;
                end
                PRESS_CHK: begin
                    if (!btn_s)             state_d = RELEASED;
                    else if (cnt_q == LAST) state_d = HELD;
                    else                    cnt_d   = cnt_q + 4'd1;
                end
                HELD: if (!btn_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = 4'd1;
                end
                RELEASE_CHK: begin
                    if (btn_s)              state_d = HELD;
                    else if (cnt_q == LAST) state_d = RELEASED;
                    else                    cnt_d   = cnt_q + 4'd1;
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    // held is decoded from the next state so the registered copy lines up with state_q
    always_comb begin
        press_evt = tick && (state_q == PRESS_CHK) && btn_s && (cnt_q == LAST);
        held_d    = (state_d == HELD) || (state_d == RELEASE_CHK);
    end

    assign held = held_q;
endmodule

module key_debouncer #(
    parameter int NUM_KEYS     = 4,
    parameter int CODE_W       = 2,
    parameter int STABLE_TICKS = 2
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                divided_clk,
    input  logic [NUM_KEYS-1:0] btn_in,
    input  logic                key_ready,
    input  logic                drop_clr,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_drop
);
    logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic                div_q, div_d;
    logic                valid_q, valid_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                drop_q, drop_d;
    logic                tick;
    logic [NUM_KEYS-1:0] evt;
    logic [CODE_W-1:0]   sel;
    logic                multi, drop_set;

    // div_q resets high so a divided_clk already high at release is not seen as an edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= 1'b1;
            valid_q <= 1'b0;
            code_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
        end
    end

    assign tick = divided_clk & ~div_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_fsm #(.STABLE_TICKS(STABLE_TICKS)) u_fsm (
            .clk_in    (clk_in),
            .rst       (rst),
            .tick      (tick),
            .btn_s     (sync2_q[g]),
            .press_evt (evt[g]),
            .held      (key_held[g])
        );
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (evt[i]) sel = CODE_W'(i);
        multi = |(evt & (evt - NUM_KEYS'(1)));
    end

    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        div_d    = divided_clk;
        valid_d  = valid_q;
        code_d   = code_q;
        drop_set = 1'b0;
        if (|evt) begin
            if (!valid_q || key_ready) begin
                valid_d  = 1'b1;
                code_d   = sel;
                drop_set = multi;
            end else begin
                drop_set = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
        drop_d = drop_set ? 1'b1 : (drop_clr ? 1'b0 : drop_q);
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_drop  = drop_q;
endmodule
